// File: rtl/rotate_sequencer.sv
// Sequencer that loads a 4-bit pattern downstream, then issues rate-divided
// step enables with direction/shift-mode controls; every output is registered.
module rotate_sequencer #(
   parameter int RATE_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              start,
   input  logic              stop,
   input  logic [3:0]        pattern,
   input  logic [RATE_W-1:0] rate,
   input  logic              dir,
   input  logic              arith,
   input  logic [CNT_W-1:0]  steps,
   output logic [3:0]        data_out,
   output logic              loadn,
   output logic              rotate_right,
   output logic              ls_right,
   output logic              step_en,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [RATE_W-1:0] RATE_ONE = 1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

   state_t            state, state_nxt;
   logic [RATE_W-1:0] div, div_nxt;
   logic [RATE_W-1:0] rate_q, rate_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  steps_q, steps_nxt;
   logic              dir_q, dir_nxt;
   logic              arith_q, arith_nxt;
   logic [3:0]        pat_nxt;
   logic              step_nxt;

   always_comb begin
      state_nxt = state;
      div_nxt   = div;
      cnt_nxt   = cnt;
      rate_nxt  = rate_q;
      steps_nxt = steps_q;
      dir_nxt   = dir_q;
      arith_nxt = arith_q;
      pat_nxt   = data_out;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               pat_nxt   = pattern;
               rate_nxt  = rate;
               steps_nxt = steps;
               dir_nxt   = dir;
               arith_nxt = arith;
            end
         end
         LOAD: begin
            div_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = RUN;
         end
         RUN: begin
            // stop wins over a step that would otherwise be issued next cycle
            if (stop) begin
               state_nxt = IDLE;
            end else if (div == rate_q) begin
               div_nxt = '0;
               cnt_nxt = cnt + CNT_ONE;
               if (steps_q != '0 && cnt_nxt == steps_q)
                  state_nxt = DONE;
            end else begin
               div_nxt = div + RATE_ONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // outputs are registered, so they are decoded from next-cycle state
      step_nxt = (state_nxt == LOAD) || (state_nxt == RUN && div_nxt == rate_nxt);
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state        <= IDLE;
         div          <= '0;
         cnt          <= '0;
         rate_q       <= '0;
         steps_q      <= '0;
         dir_q        <= 1'b0;
         arith_q      <= 1'b0;
         data_out     <= '0;
         loadn        <= 1'b1;
         rotate_right <= 1'b0;
         ls_right     <= 1'b0;
         step_en      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         div          <= div_nxt;
         cnt          <= cnt_nxt;
         rate_q       <= rate_nxt;
         steps_q      <= steps_nxt;
         dir_q        <= dir_nxt;
         arith_q      <= arith_nxt;
         data_out     <= pat_nxt;
         loadn        <= (state_nxt != LOAD);
         rotate_right <= (state_nxt != IDLE) && dir_nxt;
         ls_right     <= (state_nxt != IDLE) && arith_nxt;
         step_en      <= step_nxt;
         busy         <= (state_nxt != IDLE);
         done         <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer; outputs are packed as
// {data_out, loadn, rotate_right, ls_right, step_en, busy, done} and compared per cycle.
module tb_rotate_sequencer;

   logic       clk = 1'b0;
   logic       reset_p;
   logic       start;
   logic       stop;
   logic [3:0] pattern;
   logic [7:0] rate;
   logic       dir;
   logic       arith;
   logic [3:0] steps;
   logic [3:0] data_out;
   logic       loadn, rotate_right, ls_right, step_en, busy, done;

   int checks = 0;
   int failures = 0;

   rotate_sequencer #(.RATE_W(8), .CNT_W(4)) dut (
      .clk(clk), .reset_p(reset_p), .start(start), .stop(stop),
      .pattern(pattern), .rate(rate), .dir(dir), .arith(arith), .steps(steps),
      .data_out(data_out), .loadn(loadn), .rotate_right(rotate_right),
      .ls_right(ls_right), .step_en(step_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] obs();
      return {6'd0, data_out, loadn, rotate_right, ls_right, step_en, busy, done};
   endfunction

   function automatic logic [15:0] ex(input logic [3:0] d, input logic ln, input logic rr,
                                      input logic lr, input logic se, input logic b,
                                      input logic dn);
      return {6'd0, d, ln, rr, lr, se, b, dn};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_p = 1'b1; start = 1'b0; stop = 1'b0; pattern = 4'h0; rate = 8'd0;
      dir = 1'b0; arith = 1'b0; steps = 4'd0;
      tick(); tick();
      check("reset", obs(), ex(4'h0, 1, 0, 0, 0, 0, 0));
      reset_p = 1'b0;
      tick();
      check("idle_after_reset", obs(), ex(4'h0, 1, 0, 0, 0, 0, 0));

      // rate=2, steps=3, rotate right: steps on RUN cycles 3, 6, 9
      pattern = 4'b1001; rate = 8'd2; steps = 4'd3; dir = 1'b1; arith = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("s1_load", obs(), ex(4'h9, 0, 1, 0, 1, 1, 0));
      for (int i = 1; i <= 9; i++) begin
         tick();
         check($sformatf("s1_run%0d", i), obs(), ex(4'h9, 1, 1, 0, (i % 3 == 0), 1, 0));
      end
      tick();
      check("s1_done", obs(), ex(4'h9, 1, 1, 0, 0, 1, 1));
      tick();
      check("s1_idle", obs(), ex(4'h9, 1, 0, 0, 0, 0, 0));

      // rate=0, steps=0: free-running, counter wraps, then stop
      pattern = 4'h5; rate = 8'd0; steps = 4'd0; dir = 1'b0; arith = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("s2_load", obs(), ex(4'h5, 0, 0, 0, 1, 1, 0));
      for (int i = 1; i <= 20; i++) begin
         tick();
         check($sformatf("s2_run%0d", i), obs(), ex(4'h5, 1, 0, 0, 1, 1, 0));
      end
      stop = 1'b1;
      tick();
      check("s2_stop", obs(), ex(4'h5, 1, 0, 0, 0, 0, 0));
      tick();
      stop = 1'b0;
      check("s2_stop_idle", obs(), ex(4'h5, 1, 0, 0, 0, 0, 0));

      // start held high: one sequence, then recapture of new pattern
      pattern = 4'b0110; rate = 8'd1; steps = 4'd2; dir = 1'b0; arith = 1'b0; start = 1'b1;
      tick();
      check("s3_load", obs(), ex(4'h6, 0, 0, 0, 1, 1, 0));
      pattern = 4'b0011;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("s3_run%0d", i), obs(), ex(4'h6, 1, 0, 0, (i % 2 == 0), 1, 0));
      end
      tick();
      check("s3_done", obs(), ex(4'h6, 1, 0, 0, 0, 1, 1));
      tick();
      check("s3_idle", obs(), ex(4'h6, 1, 0, 0, 0, 0, 0));
      tick();
      check("s3_reload", obs(), ex(4'h3, 0, 0, 0, 1, 1, 0));
      tick();
      check("s3_rerun1", obs(), ex(4'h3, 1, 0, 0, 0, 1, 0));
      tick();
      check("s3_rerun2", obs(), ex(4'h3, 1, 0, 0, 1, 1, 0));

      // reset mid-RUN with start still high
      reset_p = 1'b1;
      tick();
      check("s3_reset_run", obs(), ex(4'h0, 1, 0, 0, 0, 0, 0));
      tick();
      check("s3_reset_vs_start", obs(), ex(4'h0, 1, 0, 0, 0, 0, 0));
      reset_p = 1'b0; start = 1'b0;
      tick();
      check("s3_post_reset", obs(), ex(4'h0, 1, 0, 0, 0, 0, 0));

      // shift mode, inputs disturbed after capture, stop ignored in LOAD
      pattern = 4'b1100; rate = 8'd1; steps = 4'd2; dir = 1'b0; arith = 1'b1; start = 1'b1;
      tick();
      check("s4_load", obs(), ex(4'hC, 0, 0, 1, 1, 1, 0));
      start = 1'b0; stop = 1'b1;
      pattern = 4'b0101; rate = 8'd0; dir = 1'b1; arith = 1'b0; steps = 4'd7;
      tick();
      stop = 1'b0;
      check("s4_run1", obs(), ex(4'hC, 1, 0, 1, 0, 1, 0));
      for (int i = 2; i <= 4; i++) begin
         tick();
         check($sformatf("s4_run%0d", i), obs(), ex(4'hC, 1, 0, 1, (i % 2 == 0), 1, 0));
      end
      tick();
      check("s4_done", obs(), ex(4'hC, 1, 0, 1, 0, 1, 1));
      tick();
      check("s4_idle", obs(), ex(4'hC, 1, 0, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rotate_sequencer.md
ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

Parameters
REQ-001 The block SHALL have parameter RATE_W, default 8, width of the step-rate divider field.
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the step-count field.

Interface
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_p  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 stop  input  1  abort of a running sequence.
REQ-007 pattern  input  4  value to load into the downstream rotating register.
REQ-008 rate  input  RATE_W  divider; one step every rate+1 cycles.
REQ-009 dir  input  1  0 = rotate left, 1 = rotate right.
REQ-010 arith  input  1  1 = logical shift right (zero fill) instead of rotate.
REQ-011 steps  input  CNT_W  number of steps to issue; 0 = run until stop.
REQ-012 data_out  output  4  parallel load data for downstream.
REQ-013 loadn  output  1  active-low parallel-load strobe for downstream.
REQ-014 rotate_right  output  1  direction control for downstream.
REQ-015 ls_right  output  1  shift-mode control for downstream.
REQ-016 step_en  output  1  one-cycle clock-enable pulse for the downstream register.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 done  output  1  one-cycle pulse on sequence completion.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-021 In IDLE, start=1 SHALL capture pattern, rate, dir, arith and steps into internal registers, and the FSM SHALL enter LOAD on the next cycle.
REQ-022 start SHALL be ignored in all states other than IDLE.
REQ-023 Input changes after capture SHALL have no effect until the next start.
REQ-024 LOAD SHALL last exactly one cycle, with loadn=0, step_en=1 and data_out equal to the captured pattern.
REQ-025 LOAD SHALL clear the divider counter and the step counter, then enter RUN.
REQ-026 In RUN, the divider SHALL increment every cycle.
REQ-027 When the divider equals the captured rate, step_en SHALL be 1 for one cycle, the divider SHALL return to 0, and the step counter SHALL increment.
REQ-028 With rate=0, step_en SHALL be 1 on every RUN cycle.
REQ-029 With captured steps != 0, the FSM SHALL enter DONE on the cycle after the step that makes the step counter equal steps.
REQ-030 With captured steps = 0, RUN SHALL continue indefinitely, and the step counter SHALL wrap modulo 2^CNT_W without effect.
REQ-031 stop=1 in RUN SHALL send the FSM to IDLE next cycle; stop SHALL take priority over a coincident step, so step_en=0 that cycle, and done SHALL NOT pulse.
REQ-032 stop SHALL be ignored in IDLE, LOAD and DONE.
REQ-033 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-034 rotate_right and ls_right SHALL equal the captured dir and arith while busy=1, and SHALL be 0 in IDLE.
REQ-035 data_out SHALL hold the captured pattern from LOAD until the next capture.
REQ-036 loadn SHALL be 1 in every state except LOAD.
REQ-037 step_en SHALL be 0 in IDLE and DONE.

Reset
REQ-038 reset_p=1 SHALL force the FSM to IDLE at the next edge, from any state including mid-RUN.
REQ-039 reset_p=1 SHALL clear the divider, step counter and all captured registers to 0.
REQ-040 Reset values SHALL be: data_out=0, loadn=1, rotate_right=0, ls_right=0, step_en=0, busy=0, done=0.
REQ-041 reset_p SHALL take priority over start and stop.

Verification
REQ-042 Reset while in RUN -> next cycle all outputs at reset values, busy=0.
REQ-043 pattern=4'b1001, rate=2, steps=3, dir=1, start pulse -> LOAD cycle with loadn=0 and data_out=1001; step_en pulses on RUN cycles 3, 6 and 9; done pulses one cycle later; busy=0 afterward.
REQ-044 rate=0, steps=0, start -> step_en=1 every RUN cycle; stop after 20 cycles -> IDLE next cycle, no done, step_en=0 on the stop cycle.
REQ-045 start held high throughout a sequence -> exactly one sequence runs; after returning to IDLE, start is recaptured.
REQ-046 arith=1, dir=0 captured; pattern and rate inputs changed during RUN -> ls_right=1, rotate_right=0, step timing unchanged, data_out unchanged.
